keccak_round_ctrl: RTL and testbench



---
 rtl/keccak_round_ctrl.sv | 112 +++++++++++
 tb/tb_keccak_round_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/keccak_round_ctrl.sv
// Round sequencer for the Keccak-f[1600] state register: one load cycle, ROUNDS round cycles, one done pulse.
// Defining KECCAK_CTRL_ABORT_EN adds the inAbort/outAborted pair for cancelling a running permutation.
module keccak_round_ctrl #(
   parameter int ROUNDS = 24
) (
   input  logic       inClk,
   input  logic       inRstN,
   input  logic       inStart,
   input  logic       inHold,
`ifdef KECCAK_CTRL_ABORT_EN
   input  logic       inAbort,
   output logic       outAborted,
`endif
   output logic [7:0] outRoundNumber,
   output logic       outLoad,
   output logic       outRoundEn,
   output logic       outLastRound,
   output logic       outBusy,
   output logic       outDone
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

   state_t     state;
   state_t     stateNext;
   logic [4:0] roundCnt;
   logic [4:0] roundCntNext;
   logic       abortReq;

`ifdef KECCAK_CTRL_ABORT_EN
   logic abortedP1;

   assign abortReq = inAbort;

   // Abort only cancels an active load/round phase; the pulse lags the request by one cycle.
   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         abortedP1 <= 1'b0;
      end else begin
         abortedP1 <= inAbort && ((state == LOAD) || (state == ROUND));
      end
   end

   assign outAborted = abortedP1;
`else
   assign abortReq = 1'b0;
`endif

   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         state    <= IDLE;
         roundCnt <= 5'd0;
      end else begin
         state    <= stateNext;
         roundCnt <= roundCntNext;
      end
   end

   always_comb begin
      stateNext    = state;
      roundCntNext = roundCnt;
      case (state)
         IDLE: begin
            roundCntNext = 5'd0;
            if (inStart) begin
               stateNext = LOAD;
            end
         end
         LOAD: begin
            roundCntNext = 5'd0;
            stateNext    = abortReq ? IDLE : ROUND;
         end
         ROUND: begin
            // Abort outranks hold; hold freezes everything else.
            if (abortReq) begin
               stateNext    = IDLE;
               roundCntNext = 5'd0;
            end else if (!inHold) begin
               if (roundCnt == LAST_ROUND) begin
                  stateNext    = DONE;
                  roundCntNext = 5'd0;
               end else begin
                  roundCntNext = roundCnt + 5'd1;
               end
            end
         end
         DONE: begin
            stateNext    = IDLE;
            roundCntNext = 5'd0;
         end
         default: begin
            stateNext    = IDLE;
            roundCntNext = 5'd0;
         end
      endcase
   end

   assign outRoundNumber = (state == ROUND) ? {3'b000, roundCnt} : 8'd0;
   assign outLoad        = (state == LOAD);
   assign outRoundEn     = (state == ROUND) && !inHold;
   assign outLastRound   = (state == ROUND) && (roundCnt == LAST_ROUND);
   assign outBusy        = (state != IDLE);
   assign outDone        = (state == DONE);

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Bench for keccak_round_ctrl: vector table plus scoreboard, ROUNDS=24 and ROUNDS=1 instances.
module tb_keccak_round_ctrl;

   localparam int R = 24;

   logic       clk = 1'b0;
   logic       rstN;
   logic       start0, hold0, start1, hold1, abort;
   logic [7:0] num0, num1;
   logic       load0, en0, last0, busy0, done0;
   logic       load1, en1, last1, busy1, done1;
   logic       ab0, ab1;

   always #5 clk = ~clk;

   keccak_round_ctrl #(.ROUNDS(R)) dut (
      .inClk(clk), .inRstN(rstN), .inStart(start0), .inHold(hold0),
`ifdef KECCAK_CTRL_ABORT_EN
      .inAbort(abort), .outAborted(ab0),
`endif
      .outRoundNumber(num0), .outLoad(load0), .outRoundEn(en0),
      .outLastRound(last0), .outBusy(busy0), .outDone(done0)
   );

   keccak_round_ctrl #(.ROUNDS(1)) dut1 (
      .inClk(clk), .inRstN(rstN), .inStart(start1), .inHold(hold1),
`ifdef KECCAK_CTRL_ABORT_EN
      .inAbort(1'b0), .outAborted(ab1),
`endif
      .outRoundNumber(num1), .outLoad(load1), .outRoundEn(en1),
      .outLastRound(last1), .outBusy(busy1), .outDone(done1)
   );

`ifndef KECCAK_CTRL_ABORT_EN
   assign ab0 = 1'b0;
   assign ab1 = 1'b0;
`endif

   typedef struct {
      logic       start, hold, rstN, abort, sel, chk;
      logic [7:0] num;
      logic       load, en, last, busy, done, aborted;
      string      tag;
   } vec_t;

   typedef struct {
      logic       sel;
      logic [13:0] v;
      string      tag;
   } exp_t;

   vec_t  vecs[$];
   exp_t  expQ[$];
   exp_t  e;
   logic  curSel;
   int    checks = 0;
   int    failures = 0;
   logic [13:0] gotV;

   function automatic void add(string tag, logic start, logic hold, logic rN, logic ab, logic chk,
                               logic [7:0] num, logic load, logic en, logic last, logic busy,
                               logic done, logic aborted);
      vec_t v;
      v.tag = tag; v.start = start; v.hold = hold; v.rstN = rN; v.abort = ab;
      v.sel = curSel; v.chk = chk; v.num = num; v.load = load; v.en = en;
      v.last = last; v.busy = busy; v.done = done; v.aborted = aborted;
      vecs.push_back(v);
   endfunction

   function automatic void idle(string tag);
      add(tag, 0, 0, 1, 0, 1, 8'd0, 0, 0, 0, 0, 0, 0);
   endfunction

   // cutAt >= 0 interrupts the run in that round: cutKind 0 = abort, 1 = reset.
   function automatic void addRun(string tag, int rounds, int holdAt, int holdLen,
                                  logic keep, int cutAt, int cutKind);
      add(tag, 1, 0, 1, 0, 1, 8'd0, 0, 0, 0, 0, 0, 0);
      add(tag, keep, (holdLen > 0), 1, 0, 1, 8'd0, 1, 0, 0, 1, 0, 0);
      for (int r = 0; r < rounds; r++) begin
         if (r == holdAt)
            for (int h = 0; h < holdLen; h++)
               add(tag, keep, 1, 1, 0, 1, 8'(r), 0, 0, (r == rounds - 1), 1, 0, 0);
         if (r == cutAt) begin
            add(tag, keep, 0, (cutKind != 0) ? 1'b0 : 1'b1, (cutKind == 0), 1,
                8'(r), 0, 1, (r == rounds - 1), 1, 0, 0);
            add(tag, 0, 0, 1, 0, 1, 8'd0, 0, 0, 0, 0, 0, (cutKind == 0));
            return;
         end
         add(tag, keep, 0, 1, 0, 1, 8'(r), 0, 1, (r == rounds - 1), 1, 0, 0);
      end
      add(tag, keep, 0, 1, 0, 1, 8'd0, 0, 0, 0, 1, 1, 0);
   endfunction

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         gotV = e.sel ? {num1, load1, en1, last1, busy1, done1, ab1}
                      : {num0, load0, en0, last0, busy0, done0, ab0};
         checks++;
         if (gotV !== e.v) begin
            failures++;
            $display("FAIL %s: got num=%0d load,en,last,busy,done,aborted=%b expected num=%0d flags=%b",
                     e.tag, gotV[13:6], gotV[5:0], e.v[13:6], e.v[5:0]);
         end
      end
   end

   task automatic latencyRun(string tag, int holdCycles, int expLat);
      int lat;
      bit seen;
      lat = 0;
      seen = 0;
      @(posedge clk); #1 start0 = 1;
      @(posedge clk); #1 start0 = 0;
      lat = 1;
      while (lat < 100 && !seen) begin
         if (lat >= 5 && lat < 5 + holdCycles) hold0 = 1; else hold0 = 0;
         if (done0) seen = 1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      hold0 = 0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout: no outDone within %0d cycles, expected at %0d", tag, lat, expLat);
      end else if (lat != expLat) begin
         failures++;
         $display("FAIL %s_latency: got %0d cycles expected %0d", tag, lat, expLat);
      end
      @(posedge clk); #1;
      checks++;
      if (busy0 !== 1'b0) begin
         failures++;
         $display("FAIL %s_busy_after_done: got %b expected 0", tag, busy0);
      end
   endtask

   initial begin
      rstN = 0; start0 = 0; hold0 = 0; start1 = 0; hold1 = 0; abort = 0;
      curSel = 0;
      add("reset_x", 0, 0, 0, 0, 0, 8'd0, 0, 0, 0, 0, 0, 0);
      add("reset", 0, 0, 0, 0, 1, 8'd0, 0, 0, 0, 0, 0, 0);
      idle("reset_idle"); idle("reset_idle");
      addRun("single", R, -1, 0, 0, -1, 0);
      idle("single_after"); idle("single_after");
      addRun("hold", R, 5, 3, 0, -1, 0);
      idle("hold_after");
      addRun("cont", R, -1, 0, 1, -1, 0);
      addRun("cont2", R, -1, 0, 1, -1, 0);
      idle("cont_after"); idle("cont_after");
      add("rst_start", 1, 0, 0, 0, 1, 8'd0, 0, 0, 0, 0, 0, 0);
      idle("rst_beats_start"); idle("rst_beats_start");
      addRun("midrst", R, -1, 0, 0, 12, 1);
      idle("midrst_idle");
      addRun("after_rst", R, -1, 0, 0, -1, 0);
      idle("after_rst_idle");
`ifdef KECCAK_CTRL_ABORT_EN
      addRun("abort", R, -1, 0, 0, 7, 0);
      idle("abort_pulse_end");
      add("abort_idle", 0, 0, 1, 1, 1, 8'd0, 0, 0, 0, 0, 0, 0);
      idle("abort_idle_none");
      idle("abort_idle_none");
`endif
      curSel = 1;
      addRun("r1", 1, -1, 0, 0, -1, 0);
      idle("r1_after");
      idle("r1_after");

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         rstN   = vecs[i].rstN;
         abort  = vecs[i].abort;
         start0 = vecs[i].sel ? 1'b0 : vecs[i].start;
         hold0  = vecs[i].sel ? 1'b0 : vecs[i].hold;
         start1 = vecs[i].sel ? vecs[i].start : 1'b0;
         hold1  = vecs[i].sel ? vecs[i].hold : 1'b0;
         if (vecs[i].chk) begin
            exp_t x;
            x.sel = vecs[i].sel;
            x.tag = vecs[i].tag;
`ifdef KECCAK_CTRL_ABORT_EN
            x.v = {vecs[i].num, vecs[i].load, vecs[i].en, vecs[i].last,
                   vecs[i].busy, vecs[i].done, vecs[i].aborted};
`else
            x.v = {vecs[i].num, vecs[i].load, vecs[i].en, vecs[i].last,
                   vecs[i].busy, vecs[i].done, 1'b0};
`endif
            expQ.push_back(x);
         end
      end
      @(posedge clk); #1;
      start0 = 0; start1 = 0; hold0 = 0; hold1 = 0; abort = 0; rstN = 1;
      @(negedge clk);

      latencyRun("plain", 0, R + 2);
      latencyRun("held2", 2, R + 4);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
